// File: rtl/mux2_arb_feeder_if.sv
// Handshake/bus bundle between the two input links, the feeder and the NoC mux.
interface mux2_arb_feeder_if #(
   parameter int DATA_PACKET_SIZE = 4
);
   logic                        in1_valid;
   logic [DATA_PACKET_SIZE-1:0] in1_data;
   logic                        in1_ready;
   logic                        in2_valid;
   logic [DATA_PACKET_SIZE-1:0] in2_data;
   logic                        in2_ready;
   logic [DATA_PACKET_SIZE-1:0] data_1;
   logic [DATA_PACKET_SIZE-1:0] data_2;
   logic                        select;
   logic                        out_valid;
   logic                        out_ready;

   modport master (
      output in1_valid, in1_data, in2_valid, in2_data, out_ready,
      input  in1_ready, in2_ready, data_1, data_2, select, out_valid
   );

   modport slave (
      input  in1_valid, in1_data, in2_valid, in2_data, out_ready,
      output in1_ready, in2_ready, data_1, data_2, select, out_valid
   );
endinterface

// File: rtl/mux2_arb_feeder.sv
// Two per-port FIFOs feeding a NoC 2:1 mux, with a round-robin arbiter driving select.
// Optional per-port transfer counters are enabled by defining MUX2_ARB_GRANT_CNT_EN.
module mux2_arb_feeder #(
   parameter int DATA_PACKET_SIZE = 4,
   parameter int DEPTH            = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   mux2_arb_feeder_if.slave      bus
`ifdef MUX2_ARB_GRANT_CNT_EN
   ,
   output logic [15:0]           grant_cnt_1,
   output logic [15:0]           grant_cnt_2
`else
`endif
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int W     = DATA_PACKET_SIZE;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT1 = 2'd1,
      GRANT2 = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   last_q, last_d;
   logic   sel_q, sel_d;

   logic [1:0][DEPTH-1:0][W-1:0] mem_q, mem_d;
   logic [1:0][CNT_W-1:0]        cnt_q, cnt_d, occ_s;
   logic [1:0][PTR_W-1:0]        wr_q, wr_d, rd_q, rd_d;
   logic [1:0][W-1:0]            head_q, head_d;
   logic [1:0][W-1:0]            in_data_s;
   logic [1:0]                   in_valid_s, ready_s, push_s, pop_s;
   logic                         xfer_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + {{(PTR_W-1){1'b0}}, 1'b1};
      end
   endfunction

   assign in_valid_s = {bus.in2_valid, bus.in1_valid};
   assign in_data_s  = {bus.in2_data, bus.in1_data};

   assign ready_s[0] = (cnt_q[0] < CNT_W'(DEPTH));
   assign ready_s[1] = (cnt_q[1] < CNT_W'(DEPTH));
   assign push_s     = in_valid_s & ready_s;
   assign xfer_s     = (state_q != IDLE) && bus.out_ready;
   assign pop_s[0]   = xfer_s && (state_q == GRANT1);
   assign pop_s[1]   = xfer_s && (state_q == GRANT2);

   // Head register tracks the oldest entry; once empty it keeps the last popped value.
   always_comb begin
      mem_d  = mem_q;
      cnt_d  = cnt_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      head_d = head_q;
      occ_s  = '0;
      for (int p = 0; p < 2; p++) begin
         occ_s[p] = cnt_q[p] - {{(CNT_W-1){1'b0}}, pop_s[p]};
         if (push_s[p]) begin
            mem_d[p][wr_q[p]] = in_data_s[p];
            wr_d[p]           = ptr_inc(wr_q[p]);
         end else begin
            wr_d[p] = wr_q[p];
         end
         if (pop_s[p]) begin
            rd_d[p] = ptr_inc(rd_q[p]);
         end else begin
            rd_d[p] = rd_q[p];
         end
         cnt_d[p] = occ_s[p] + {{(CNT_W-1){1'b0}}, push_s[p]};
         if (occ_s[p] != {CNT_W{1'b0}}) begin
            head_d[p] = mem_q[p][rd_d[p]];
         end else if (push_s[p]) begin
            head_d[p] = in_data_s[p];
         end else begin
            head_d[p] = head_q[p];
         end
      end
   end

   // Arbitration uses post-pop occupancy only, so a fresh push waits one edge.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      sel_d   = sel_q;
      if ((state_q == IDLE) || xfer_s) begin
         case ({occ_s[1] != {CNT_W{1'b0}}, occ_s[0] != {CNT_W{1'b0}}})
            2'b11: begin
               if (last_q) begin
                  state_d = GRANT1;
                  last_d  = 1'b0;
                  sel_d   = 1'b0;
               end else begin
                  state_d = GRANT2;
                  last_d  = 1'b1;
                  sel_d   = 1'b1;
               end
            end
            2'b01: begin
               state_d = GRANT1;
               last_d  = 1'b0;
               sel_d   = 1'b0;
            end
            2'b10: begin
               state_d = GRANT2;
               last_d  = 1'b1;
               sel_d   = 1'b1;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         sel_q   <= 1'b0;
         mem_q   <= '0;
         cnt_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         head_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         sel_q   <= sel_d;
         mem_q   <= mem_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         head_q  <= head_d;
      end
   end

   assign bus.in1_ready = ready_s[0];
   assign bus.in2_ready = ready_s[1];
   assign bus.data_1    = head_q[0];
   assign bus.data_2    = head_q[1];
   assign bus.select    = sel_q;
   assign bus.out_valid = (state_q != IDLE);

`ifdef MUX2_ARB_GRANT_CNT_EN
   logic [1:0][15:0] gcnt_q;

   // Saturating per-port transfer counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gcnt_q <= '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (pop_s[p] && (gcnt_q[p] != 16'hFFFF)) begin
               gcnt_q[p] <= gcnt_q[p] + 16'd1;
            end else begin
               gcnt_q[p] <= gcnt_q[p];
            end
         end
      end
   end

   assign grant_cnt_1 = gcnt_q[0];
   assign grant_cnt_2 = gcnt_q[1];
`else
`endif
endmodule

// File: tb/tb_mux2_arb_feeder.sv
// Directed bench for mux2_arb_feeder: a vector table for round-robin and single-port
// traffic, then hand-written backpressure, full-FIFO and asynchronous-reset sequences.
module tb_mux2_arb_feeder;
   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   mux2_arb_feeder_if #(.DATA_PACKET_SIZE(4)) bus ();

`ifdef MUX2_ARB_GRANT_CNT_EN
   logic [15:0] grant_cnt_1;
   logic [15:0] grant_cnt_2;
`else
`endif

   mux2_arb_feeder #(.DATA_PACKET_SIZE(4), .DEPTH(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef MUX2_ARB_GRANT_CNT_EN
      ,
      .grant_cnt_1 (grant_cnt_1),
      .grant_cnt_2 (grant_cnt_2)
`else
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       v1;
      logic [3:0] d1;
      logic       v2;
      logic [3:0] d2;
      logic       rdy;
      logic [11:0] exp;   // {in1_ready, in2_ready, out_valid, select, data_1, data_2}
   } vec_t;

   vec_t tbl [9];

   function automatic logic [11:0] mk(input logic r1, input logic r2, input logic ov,
                                      input logic sel, input logic [3:0] a, input logic [3:0] b);
      return {r1, r2, ov, sel, a, b};
   endfunction

   function automatic logic [11:0] outs();
      return {bus.in1_ready, bus.in2_ready, bus.out_valid, bus.select, bus.data_1, bus.data_2};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v1, input logic [3:0] d1, input logic v2,
                        input logic [3:0] d2, input logic rdy);
      bus.in1_valid = v1;
      bus.in1_data  = d1;
      bus.in2_valid = v2;
      bus.in2_data  = d2;
      bus.out_ready = rdy;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      clk   = 1'b0;
      reset = 1'b1;
      drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);

      // Round-robin from reset (preload with out_ready low), then single-port latency.
      tbl[0] = {1'b1, 4'h1, 1'b1, 4'hA, 1'b0, mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h1, 4'hA)};
      tbl[1] = {1'b1, 4'h2, 1'b1, 4'hB, 1'b0, mk(1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 4'hA)};
      tbl[2] = {1'b0, 4'h0, 1'b0, 4'h0, 1'b1, mk(1'b1, 1'b0, 1'b1, 1'b1, 4'h2, 4'hA)};
      tbl[3] = {1'b0, 4'h0, 1'b0, 4'h0, 1'b1, mk(1'b1, 1'b1, 1'b1, 1'b0, 4'h2, 4'hB)};
      tbl[4] = {1'b0, 4'h0, 1'b0, 4'h0, 1'b1, mk(1'b1, 1'b1, 1'b1, 1'b1, 4'h2, 4'hB)};
      tbl[5] = {1'b0, 4'h0, 1'b0, 4'h0, 1'b1, mk(1'b1, 1'b1, 1'b0, 1'b1, 4'h2, 4'hB)};
      tbl[6] = {1'b1, 4'h3, 1'b0, 4'h0, 1'b1, mk(1'b1, 1'b1, 1'b0, 1'b1, 4'h3, 4'hB)};
      tbl[7] = {1'b0, 4'h0, 1'b0, 4'h0, 1'b1, mk(1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 4'hB)};
      tbl[8] = {1'b0, 4'h0, 1'b0, 4'h0, 1'b1, mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 4'hB)};

      #1 reset = 1'b0;
      tick();
      tick();
      check("reset_state", 32'(outs()), 32'(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0)));
      reset = 1'b1;

      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].v1, tbl[i].d1, tbl[i].v2, tbl[i].d2, tbl[i].rdy);
         tick();
         check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
`ifdef MUX2_ARB_GRANT_CNT_EN
         if (i == 5) begin
            check("rr_grant_cnt_1", 32'(grant_cnt_1), 32'd2);
            check("rr_grant_cnt_2", 32'(grant_cnt_2), 32'd2);
         end
`else
`endif
      end

      // Backpressure: port 1 granted and held while port 2 fills.
      drive(1'b1, 4'h5, 1'b0, 4'h0, 1'b0);
      tick();
      drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
      tick();
      check("bp_grant1", 32'({bus.out_valid, bus.select, bus.data_1}), 32'({1'b1, 1'b0, 4'h5}));
      for (int c = 0; c < 5; c++) begin
         drive(1'b0, 4'h0, (c == 0), 4'h9, 1'b0);
         tick();
         check($sformatf("bp_hold%0d", c), 32'({bus.out_valid, bus.select, bus.data_1}),
               32'({1'b1, 1'b0, 4'h5}));
      end
      drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
      tick();
      check("bp_next_grant2", 32'({bus.out_valid, bus.select, bus.data_2}), 32'({1'b1, 1'b1, 4'h9}));
      tick();
      check("bp_idle", 32'(bus.out_valid), 32'd0);

      // Full FIFO1: third packet waits for the first transfer, no write-through.
      drive(1'b1, 4'h6, 1'b0, 4'h0, 1'b0);
      tick();
      check("full_push1_ready", 32'(bus.in1_ready), 32'd1);
      bus.in1_data = 4'h7;
      tick();
      check("full_push2", 32'({bus.in1_ready, bus.out_valid, bus.data_1}), 32'({1'b0, 1'b1, 4'h6}));
      bus.in1_data = 4'h8;
      tick();
      check("full_stall", 32'({bus.in1_ready, bus.data_1}), 32'({1'b0, 4'h6}));
      bus.out_ready = 1'b1;
      tick();
      check("full_after_xfer", 32'({bus.in1_ready, bus.out_valid, bus.data_1}), 32'({1'b1, 1'b1, 4'h7}));
      bus.out_ready = 1'b0;
      tick();
      check("full_third_push", 32'(bus.in1_ready), 32'd0);
      drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
      tick();
      check("full_drain_7", 32'({bus.out_valid, bus.data_1}), 32'({1'b1, 4'h8}));
      tick();
      check("full_drain_8", 32'({bus.in1_ready, bus.out_valid}), 32'({1'b1, 1'b0}));

      // Asynchronous reset with both FIFOs holding packets and port 2 granted.
      drive(1'b1, 4'hC, 1'b1, 4'hD, 1'b0);
      tick();
      drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
      tick();
      check("pre_reset_grant2", 32'({bus.out_valid, bus.select, bus.data_2}), 32'({1'b1, 1'b1, 4'hD}));
      #2 reset = 1'b0;
      #1;
      check("async_reset", 32'(outs()), 32'(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0)));
      drive(1'b1, 4'hF, 1'b1, 4'hF, 1'b1);
      tick();
      check("reset_ignores_valid", 32'(outs()), 32'(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0)));
`ifdef MUX2_ARB_GRANT_CNT_EN
      check("reset_grant_cnt", 32'({grant_cnt_1, grant_cnt_2}), 32'd0);
`else
`endif
      drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
      reset = 1'b1;
      drive(1'b1, 4'hE, 1'b1, 4'h7, 1'b0);
      tick();
      drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
      tick();
      check("post_reset_port1_first", 32'({bus.out_valid, bus.select, bus.data_1}),
            32'({1'b1, 1'b0, 4'hE}));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mux2_arb_feeder.md
Name: mux2_arb_feeder

Overview:
- Upstream stage of the NoC two-input multiplexer.
- Buffers packets from two input links in per-port FIFOs and presents both FIFO heads on data_1/data_2.
- Drives the mux select from a round-robin arbiter.
- Uses a valid/ready handshake so the mux output can be consumed by a downstream router stage.

Parameters:
- DATA_PACKET_SIZE, 4: packet width in bits.
- DEPTH, 2: entries per input FIFO; must be 2 or more.
- CNT_W, $clog2(DEPTH+1): FIFO occupancy counter width (derived; not overridden).

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in1_valid  in  1  port-1 packet valid.
- in1_data  in  DATA_PACKET_SIZE  port-1 packet.
- in1_ready  out  1  port-1 FIFO can accept.
- in2_valid  in  1  port-2 packet valid.
- in2_data  in  DATA_PACKET_SIZE  port-2 packet.
- in2_ready  out  1  port-2 FIFO can accept.
- data_1  out  DATA_PACKET_SIZE  FIFO-1 head, to mux data_1.
- data_2  out  DATA_PACKET_SIZE  FIFO-2 head, to mux data_2.
- select  out  1  0 = port 1, 1 = port 2; to mux select.
- out_valid  out  1  selected head is valid.
- out_ready  in  1  downstream accepts the selected packet.

Behaviour:
- Reset (reset low, asynchronous): FIFOs empty, storage cleared to 0.
  - data_1 = data_2 = 0, select = 0, out_valid = 0, in1_ready = in2_ready = 1.
  - Arbiter state = IDLE; last-granted pointer = port 2, so port 1 wins first.
- FIFO push: inX_ready = (countX < DEPTH). A push occurs when inX_valid && inX_ready at the clock edge.
  - No write-through when full, even if a pop occurs in the same cycle.
- FIFO head: data_X is the registered head. When the FIFO is empty it holds the last popped value (0 after reset).
- Pointers wrap modulo DEPTH. Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- FSM states:
  - IDLE: out_valid = 0; select holds its previous value.
  - GRANT1: out_valid = 1, select = 0.
  - GRANT2: out_valid = 1, select = 1.
- Transfer = out_valid && out_ready; it pops the granted FIFO on that edge.
- Next-state rule, evaluated at each edge when in IDLE or on a transfer, using occupancy after this edge's pop (new pushes excluded):
  - Both ports non-empty: grant the port opposite the last-granted pointer.
  - One port non-empty: grant that port.
  - Neither non-empty: go to IDLE.
  - The last-granted pointer updates on entry to GRANT1 or GRANT2.
- Hold: in GRANTx with out_ready = 0, state, select and data_X are frozen. No re-arbitration occurs, even if the other port fills.
- Latency: a packet pushed into an empty block at edge N gives out_valid = 1 after edge N+1.
- Back-to-back: with both FIFOs occupied and out_ready = 1, one transfer per cycle, alternating ports, with no bubble.
- in_valid is ignored while reset is asserted. Asserting reset mid-packet discards all buffered packets.

Optional Feature:
- Macro: MUX2_ARB_GRANT_CNT_EN.
- Defined: adds outputs grant_cnt_1 and grant_cnt_2, each 16 bits.
  - Each counts transfers from its port and saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset mid-traffic: assert reset asynchronously with both FIFOs holding packets.
  - Required: out_valid, select, data_1 and data_2 go to 0 immediately, without waiting for a clock edge.
  - Required: in1_ready = in2_ready = 1.
- Single port: push 4'h3 on in1 at edge N with out_ready = 1.
  - Required: out_valid = 1, select = 0, data_1 = 3 after edge N+1.
  - Required: out_valid = 0 after edge N+2.
- Round-robin: preload FIFO1 with {1,2} and FIFO2 with {A,B}, then hold out_ready = 1.
  - Required: select = 0,1,0,1 on consecutive cycles, with selected data 1,A,2,B.
  - Required: then IDLE.
- Backpressure: GRANT1 showing 4'h5, out_ready = 0 for 5 cycles while in2 pushes 4'h9.
  - Required: select = 0 and data_1 = 5 stay stable.
  - Required: on out_ready = 1, the next grant is port 2 with data_2 = 9.
- Full, DEPTH = 2, out_ready = 0: push 3 packets on in1 with in1_valid held.
  - Required: in1_ready = 0 after the 2nd push; the 3rd packet is accepted only on the edge after the first transfer.
- With MUX2_ARB_GRANT_CNT_EN: after the round-robin test, grant_cnt_1 = 2 and grant_cnt_2 = 2.
